// File: rtl/spi_target_port_pkg.sv
// Shared types and default constants for the SPI target port.
package spi_target_port_pkg;
  localparam int DATA_W_DEF      = 8;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_e;
endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with single-clk
// rise/fall pulses derived from the synchronized value.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= (r_sync << 1) | STAGES'(d);
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign q    = r_sync[STAGES-1];
  assign rise =  q & ~r_prev;
  assign fall = ~q &  r_prev;
endmodule

// File: rtl/spi_target_port.sv
// SPI mode-0 target with a one-word TX holding register and RX word output.
// Optional sticky status flags enabled by defining SPI_TARGET_STATUS_EN.
module spi_target_port
  import spi_target_port_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_cs,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy
`ifdef SPI_TARGET_STATUS_EN
  ,
  input  logic              rx_ack,
  input  logic              status_clr,
  output logic              rx_overrun,
  output logic              tx_underrun
`endif
);
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic w_cs_q, w_cs_rise, w_cs_fall;
  logic w_sclk_rise, w_sclk_fall, w_sclk_q_unused;
  logic w_mosi_q, w_mosi_rise_unused, w_mosi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .d(spi_cs),
    .q(w_cs_q), .rise(w_cs_rise), .fall(w_cs_fall));
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(spi_sclk),
    .q(w_sclk_q_unused), .rise(w_sclk_rise), .fall(w_sclk_fall));
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .d(spi_mosi),
    .q(w_mosi_q), .rise(w_mosi_rise_unused), .fall(w_mosi_fall_unused));

  state_e            r_state, w_next;
  logic [DATA_W-1:0] r_hold, r_tx_shift, r_rx_shift, r_rx_data;
  logic              r_hold_full, r_rx_valid;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] w_rx_next;
  logic              w_word_done, w_take;

  assign w_rx_next   = {r_rx_shift[DATA_W-2:0], w_mosi_q};
  assign w_word_done = (r_state == SHIFT) && w_sclk_rise && !w_cs_rise &&
                       (r_cnt == CNT_W'(DATA_W - 1));
  assign w_take      = (r_state == LOAD) || w_word_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_cs_fall) w_next = LOAD;
      LOAD:    w_next = SHIFT;
      SHIFT:   if (w_cs_rise) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_tx_shift  <= '0;
      r_rx_shift  <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_rx_valid <= 1'b0;
      // The falling edge right after a word's last rise (counter wrapped to 0)
      // must not shift, or the freshly reloaded MSB would be lost.
      if (w_take) begin
        r_tx_shift  <= r_hold_full ? r_hold : '0;
        r_hold_full <= 1'b0;
      end else if (r_state == SHIFT && w_sclk_fall && r_cnt != '0) begin
        r_tx_shift <= r_tx_shift << 1;
      end
      // Accept after the take so a same-clk load lands in the emptied register.
      if (tx_valid && !r_hold_full) begin
        r_hold      <= tx_data;
        r_hold_full <= 1'b1;
      end
      if (r_state == SHIFT) begin
        if (w_cs_rise) begin
          r_cnt <= '0;
        end else if (w_sclk_rise) begin
          r_rx_shift <= w_rx_next;
          if (w_word_done) begin
            r_cnt      <= '0;
            r_rx_data  <= w_rx_next;
            r_rx_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign spi_miso_oe = ~w_cs_q;
  assign spi_miso    = spi_miso_oe & r_tx_shift[DATA_W-1];
  assign tx_ready    = ~r_hold_full;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign busy        = (r_state != IDLE);

`ifdef SPI_TARGET_STATUS_EN
  logic r_rx_pend, r_rx_overrun, r_tx_underrun;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_pend     <= 1'b0;
      r_rx_overrun  <= 1'b0;
      r_tx_underrun <= 1'b0;
    end else begin
      if (w_word_done)  r_rx_pend <= 1'b1;
      else if (rx_ack)  r_rx_pend <= 1'b0;
      if (status_clr) begin
        r_rx_overrun  <= 1'b0;
        r_tx_underrun <= 1'b0;
      end
      if (w_word_done && r_rx_pend && !rx_ack) r_rx_overrun  <= 1'b1;
      if (w_take && !r_hold_full)              r_tx_underrun <= 1'b1;
    end
  end

  assign rx_overrun  = r_rx_overrun;
  assign tx_underrun = r_tx_underrun;
`endif
endmodule

// File: tb/tb_spi_target_port.sv
// Self-checking bench: bit-banged SPI initiator at clk/16 against a word-level model.
module tb_spi_target_port;
  localparam int HALF = 8;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       spi_cs = 1'b1, spi_sclk = 1'b0, spi_mosi = 1'b0;
  logic       spi_miso, spi_miso_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, busy;
`ifdef SPI_TARGET_STATUS_EN
  logic       rx_ack = 1'b1, status_clr = 1'b0;
  logic       rx_overrun, tx_underrun;
`endif

  int         n_cmp = 0, n_err = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_got[$];

  spi_target_port dut (
    .clk(clk), .rst_n(rst_n), .spi_cs(spi_cs), .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
`ifdef SPI_TARGET_STATUS_EN
    , .rx_ack(rx_ack), .status_clr(status_clr),
    .rx_overrun(rx_overrun), .tx_underrun(tx_underrun)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // TX producer: offers the head of tx_q, pops it once a handshake has occurred.
  initial begin
    logic rdy_q;
    rdy_q = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        tx_valid = 1'b0;
        rdy_q    = 1'b0;
      end else begin
        if (tx_valid && rdy_q) void'(tx_q.pop_front());
        rdy_q    = tx_ready;
        tx_valid = (tx_q.size() > 0);
        if (tx_valid) tx_data = tx_q[0];
      end
    end
  end

  always @(negedge clk) if (rst_n && rx_valid) rx_got.push_back(rx_data);

  task automatic spi_bit(input logic b, output logic r);
    spi_mosi = b;
    repeat (HALF) @(negedge clk);
    spi_sclk = 1'b1;
    r = spi_miso;
    repeat (HALF) @(negedge clk);
    spi_sclk = 1'b0;
  endtask

  task automatic spi_word(input logic [7:0] tx, output logic [7:0] rx);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], b);
      rx[i] = b;
    end
  endtask

  task automatic cs_start();
    spi_cs = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic cs_end();
    repeat (HALF) @(negedge clk);
    spi_cs = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    logic [7:0] r, m, w0, prev_m, exp_r;
    logic       b;

    repeat (3) @(negedge clk);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_miso", spi_miso, 0);
    chk("rst_miso_oe", spi_miso_oe, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // basic transfer
    tx_q.push_back(8'hA5);
    repeat (4) @(negedge clk);
    chk("basic_hold_full", tx_ready, 0);
    cs_start();
    chk("basic_busy", busy, 1);
    chk("basic_oe", spi_miso_oe, 1);
    spi_word(8'h3C, r);
    cs_end();
    chk("basic_miso", r, 8'hA5);
    chk("basic_nvalid", rx_got.size(), 1);
    if (rx_got.size() > 0) chk("basic_rx", rx_got[0], 8'h3C);
    chk("basic_rx_data", rx_data, 8'h3C);
    chk("basic_idle", busy, 0);
    chk("basic_oe_off", spi_miso_oe, 0);
    rx_got.delete();
`ifdef SPI_TARGET_STATUS_EN
    status_clr = 1'b1; @(negedge clk); status_clr = 1'b0;
`endif

    // underrun
    cs_start();
    spi_word(8'h01, r);
    cs_end();
    chk("under_miso", r, 8'h00);
    chk("under_nvalid", rx_got.size(), 1);
    chk("under_rx_data", rx_data, 8'h01);
`ifdef SPI_TARGET_STATUS_EN
    chk("under_flag", tx_underrun, 1);
    status_clr = 1'b1; @(negedge clk); status_clr = 1'b0;
    @(negedge clk);
    chk("under_clr", tx_underrun, 0);
`endif
    rx_got.delete();

    // back-to-back words in one frame
    tx_q.push_back(8'h11);
    tx_q.push_back(8'h22);
    repeat (4) @(negedge clk);
    cs_start();
    spi_word(8'h10, r);
    chk("b2b_miso0", r, 8'h11);
    spi_word(8'h20, r);
    chk("b2b_miso1", r, 8'h22);
    cs_end();
    chk("b2b_nvalid", rx_got.size(), 2);
    if (rx_got.size() == 2) begin
      chk("b2b_rx0", rx_got[0], 8'h10);
      chk("b2b_rx1", rx_got[1], 8'h20);
    end
    rx_got.delete();

    // abort after 5 bits
    cs_start();
    for (int i = 0; i < 5; i++) spi_bit(1'($urandom), b);
    cs_end();
    chk("abort_nvalid", rx_got.size(), 0);
    chk("abort_rx_hold", rx_data, 8'h20);
    cs_start();
    spi_word(8'h7E, r);
    cs_end();
    chk("abort_next_nvalid", rx_got.size(), 1);
    chk("abort_next_rx", rx_data, 8'h7E);
    rx_got.delete();

    // reset mid-frame after bit 3
    tx_q.push_back(8'h5A);
    repeat (4) @(negedge clk);
    cs_start();
    for (int i = 0; i < 3; i++) spi_bit(1'($urandom), b);
    rst_n = 1'b0;
    #1;
    chk("mrst_tx_ready", tx_ready, 1);
    chk("mrst_busy", busy, 0);
    chk("mrst_rx_data", rx_data, 0);
    chk("mrst_rx_valid", rx_valid, 0);
    chk("mrst_miso", spi_miso, 0);
    chk("mrst_oe", spi_miso_oe, 0);
    spi_cs = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    rx_got.delete();
    tx_q.push_back(8'hC3);
    repeat (4) @(negedge clk);
    m = 8'($urandom);
    cs_start();
    spi_word(m, r);
    cs_end();
    chk("mrst_next_miso", r, 8'hC3);
    chk("mrst_next_rx", rx_data, m);
    chk("mrst_next_nvalid", rx_got.size(), 1);
    rx_got.delete();

    // echo loop: target answers each frame with (previous received word + 1)
    w0 = 8'($urandom);
    tx_q.push_back(w0);
    prev_m = 8'h00;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      m = 8'($urandom);
      exp_r = (k == 0) ? w0 : 8'(prev_m + 8'd1);
      cs_start();
      spi_word(m, r);
      cs_end();
      chk("echo_miso", r, exp_r);
      chk("echo_nvalid", rx_got.size(), 1);
      if (rx_got.size() > 0) begin
        chk("echo_rx", rx_got[0], m);
        tx_q.push_back(8'(rx_got[0] + 8'd1));
      end
      prev_m = m;
      rx_got.delete();
      repeat (4) @(negedge clk);
    end
`ifdef SPI_TARGET_STATUS_EN
    chk("no_overrun", rx_overrun, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/spi_target_port.md
SPI_TARGET_PORT -- requirements
Module: spi_target_port

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter DATA_W, default 8: bits per SPI word, MSB first.
REQ-003 Parameter SYNC_STAGES, default 2: synchronizer flops on spi_cs, spi_sclk and spi_mosi.
REQ-004 Port clk, input, 1: system clock; all logic is on its rising edge.
REQ-005 Port rst_n, input, 1: asynchronous active-low reset.
REQ-006 Port spi_cs, input, 1: active-low chip select from the initiator.
REQ-007 Port spi_sclk, input, 1: SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-008 Port spi_mosi, input, 1: initiator-to-target data.
REQ-009 Port spi_miso, output, 1: target-to-initiator data.
REQ-010 Port spi_miso_oe, output, 1: MISO drive enable; high while the synchronized spi_cs is low.
REQ-011 Port tx_data, input, DATA_W: next word to send.
REQ-012 Port tx_valid, input, 1: tx_data is valid.
REQ-013 Port tx_ready, output, 1: the TX holding register is empty.
REQ-014 Port rx_data, output, DATA_W: last fully received word.
REQ-015 Port rx_valid, output, 1: one-clk pulse when rx_data updates.
REQ-016 Port busy, output, 1: the FSM is not in IDLE.

Function
REQ-017 spi_cs, spi_sclk and spi_mosi SHALL pass through SYNC_STAGES flops; edges are detected on the synchronized values.
REQ-018 spi_sclk frequency SHALL be at most clk/8; behaviour above this rate is unspecified.
REQ-019 FSM states and transitions SHALL be:
- IDLE -> LOAD on a synchronized spi_cs falling edge.
- LOAD -> SHIFT after one clk.
- SHIFT -> IDLE on a synchronized spi_cs rising edge.
REQ-020 In LOAD, the shift register SHALL take the holding register if it is full (the holding register then empties), else all zeros (underrun).
REQ-021 spi_miso SHALL present shift_reg[DATA_W-1] from LOAD+1 onward; the initiator must wait at least SYNC_STAGES+3 clk after spi_cs falls before the first sclk rise.
REQ-022 On each synchronized sclk rising edge in SHIFT, spi_mosi SHALL be sampled into rx_shift[0] and the bit counter SHALL increment.
REQ-023 On each synchronized sclk falling edge in SHIFT, the TX shift register SHALL shift left by one.
REQ-024 When the bit counter reaches DATA_W, the block SHALL, in the same clk:
- copy rx_shift to rx_data and pulse rx_valid for exactly 1 clk;
- wrap the counter to 0;
- reload the TX shift register as in REQ-020, so back-to-back words within one frame are supported.
REQ-025 tx_ready SHALL equal "holding register empty"; the register loads when tx_valid && tx_ready.
REQ-026 If a load and a shift-register take occur in the same clk, the take SHALL complete first and the new word is then accepted into the holding register.
REQ-027 If spi_cs rises mid-word (counter ≠ 0), the partial word SHALL be discarded: no rx_valid, counter cleared, holding register untouched.
REQ-028 rx_data SHALL hold its value until the next complete word.
REQ-029 When spi_miso_oe is low, spi_miso SHALL be driven 0.

Reset
REQ-030 On rst_n low, asynchronously:
- FSM = IDLE, counter = 0, shift registers and holding register cleared;
- tx_ready = 1, rx_data = 0, rx_valid = 0, busy = 0, spi_miso = 0, spi_miso_oe = 0;
- synchronizer flops reset to spi_cs = 1, spi_sclk = 0, spi_mosi = 0.
REQ-031 Reset asserted mid-frame SHALL abort the frame; after release, the block SHALL wait for a fresh spi_cs falling edge.

Configuration
REQ-032 With SPI_TARGET_STATUS_EN defined, the block SHALL add two sticky outputs, cleared by input status_clr:
- rx_overrun, 1 bit: a word completes while the previous rx_valid has not been acknowledged by input rx_ack;
- tx_underrun, 1 bit: a zero word is loaded in LOAD/reload.
REQ-033 Without SPI_TARGET_STATUS_EN, these ports and their logic SHALL be absent, and the function is otherwise identical.

Structure
REQ-034 A shared package SHALL hold the FSM state enum (IDLE, LOAD, SHIFT) and the default constants DATA_W_DEF=8 and SYNC_STAGES_DEF=2.
REQ-035 One sub-module, spi_sync_edge, SHALL implement the synchronizer chain plus rise/fall pulses and be instanced three times.

Verification
REQ-036 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Basic transfer: tx 0xA5 preloaded; initiator sends 0x3C at clk/16 -> initiator reads 0xA5; rx_data=0x3C with one rx_valid pulse.
- Underrun: no tx preloaded; initiator sends 0x01 -> initiator reads 0x00; with STATUS_EN, tx_underrun=1.
- Back-to-back words: two words in one frame, tx 0x11 then 0x22 supplied on tx_ready; initiator sends 0x10, 0x20 -> reads 0x11, 0x22; two rx_valid pulses.
- Abort: spi_cs rises after 5 bits -> no rx_valid; next frame sending 0x7E -> rx_data=0x7E.
- Reset mid-frame: rst_n low after bit 3 -> all outputs at reset values; next frame passes correctly.
- Echo loop: the bench returns rx+1 as the next tx word over 16 frames -> every initiator word equals the previous target word +1.
